// File: rtl/lcd_bus_receiver.sv
// rtl/lcd_bus_receiver.sv - HD44780-style LCD bus receiver with a 2x16 DDRAM shadow
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   lcd_rs, lcd_rw, lcd_e    bus control; a transaction is taken on the falling edge of lcd_e
//   lcd_data[7:0]            bus data
//   rd_index[4:0]            shadow read index (0-15 line 1, 16-31 line 2)
//   rd_char[7:0]             registered shadow character at rd_index
//   cursor_addr[6:0]         DDRAM address counter
//   disp_on/cursor_on/blink_on  display-control D/C/B bits
//   busy                     high while the clear-fill runs
//   wr_strobe                one-cycle pulse per accepted data write
//   err                      one-cycle pulse on a protocol error

module lcd_bus_receiver #(
  parameter logic [7:0] BLANK_CHAR = 8'h20,
  parameter int         LINE_LEN   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_index,
  output logic [7:0] rd_char,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       wr_strobe,
  output logic       err
);

  localparam int         NUM_CHARS = 2 * LINE_LEN;
  localparam logic [4:0] LAST_IDX  = 5'(NUM_CHARS - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Bus sampling registers
  logic       e_q, rs_q, rw_q;
  logic [7:0] d_q;

  // Control state
  logic [0:0] state_q, state_d;
  logic [4:0] clr_idx_q, clr_idx_d;
  logic [6:0] cursor_q, cursor_d;
  logic       id_q, id_d;
  logic       cg_q, cg_d;
  logic       disp_q, disp_d;
  logic       curs_q, curs_d;
  logic       blink_q, blink_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       err_q, err_d;

  // Shadow storage
  logic [7:0] mem_q [NUM_CHARS];
  logic [7:0] rd_char_q;
  logic       mem_we;
  logic [4:0] mem_waddr;
  logic [7:0] mem_wdata;

  logic fall;
  logic ddram_bad_lo;
  logic ddram_bad_hi;
  logic line_visible;

  assign fall = e_q & ~lcd_e;

  // Addresses that fall in the gaps between the two 40-character lines
  assign ddram_bad_lo = (d_q[6:0] >= 7'h28) && (d_q[6:0] <= 7'h3F);
  assign ddram_bad_hi = (d_q[6:0] >= 7'h68);

  // 0x00-0x0F and 0x40-0x4F are the visible columns; bit 6 selects the line
  assign line_visible = (cursor_q[5:4] == 2'b00);

  // Cursor step across the two 40-entry lines, wrapping line to line
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    cursor_d    = cursor_q;
    id_d        = id_q;
    cg_d        = cg_q;
    disp_d      = disp_q;
    curs_d      = curs_q;
    blink_d     = blink_q;
    wr_strobe_d = 1'b0;
    err_d       = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = clr_idx_q;
    mem_wdata   = BLANK_CHAR;

    if (state_q == ST_CLEAR) begin
      // Blank one entry per cycle; any bus edge arriving now is lost
      mem_we    = 1'b1;
      clr_idx_d = clr_idx_q + 5'd1;
      if (clr_idx_q == LAST_IDX) begin
        state_d = ST_IDLE;
      end
      if (fall) begin
        err_d = 1'b1;
      end
    end else if (fall) begin
      if (rw_q) begin
        err_d = 1'b1;
      end else if (rs_q) begin
        if (!cg_q) begin
          wr_strobe_d = 1'b1;
          cursor_d    = step_addr(cursor_q, id_q);
          mem_we      = line_visible;
          mem_waddr   = {cursor_q[6], cursor_q[3:0]};
          mem_wdata   = d_q;
        end
      end else begin
        casez (d_q)
          8'b1???????: begin
            cg_d = 1'b0;
            if (ddram_bad_lo) begin
              cursor_d = 7'h40;
              err_d    = 1'b1;
            end else if (ddram_bad_hi) begin
              cursor_d = 7'h00;
              err_d    = 1'b1;
            end else begin
              cursor_d = d_q[6:0];
            end
          end
          8'b01??????: cg_d = 1'b1;
          8'b001?????: begin
            // function set: accepted, nothing to track
          end
          8'b0001????: begin
            if (!d_q[3]) begin
              cursor_d = step_addr(cursor_q, d_q[2]);
            end
          end
          8'b00001???: {disp_d, curs_d, blink_d} = d_q[2:0];
          8'b000001??: id_d = d_q[1];
          8'b0000001?: cursor_d = 7'h00;
          8'b00000001: begin
            state_d   = ST_CLEAR;
            clr_idx_d = 5'd0;
            cursor_d  = 7'h00;
            id_d      = 1'b1;
          end
          default: begin
            // 0x00: no operation
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      d_q         <= 8'h00;
      state_q     <= ST_IDLE;
      clr_idx_q   <= 5'd0;
      cursor_q    <= 7'h00;
      id_q        <= 1'b1;
      cg_q        <= 1'b0;
      disp_q      <= 1'b0;
      curs_q      <= 1'b0;
      blink_q     <= 1'b0;
      wr_strobe_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      e_q         <= lcd_e;
      rs_q        <= lcd_rs;
      rw_q        <= lcd_rw;
      d_q         <= lcd_data;
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      cursor_q    <= cursor_d;
      id_q        <= id_d;
      cg_q        <= cg_d;
      disp_q      <= disp_d;
      curs_q      <= curs_d;
      blink_q     <= blink_d;
      wr_strobe_q <= wr_strobe_d;
      err_q       <= err_d;
    end
  end

  // Read returns the pre-write value when reading an entry being written
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_char_q <= BLANK_CHAR;
      for (int i = 0; i < NUM_CHARS; i++) begin
        mem_q[i] <= BLANK_CHAR;
      end
    end else begin
      rd_char_q <= mem_q[rd_index];
      if (mem_we) begin
        mem_q[mem_waddr] <= mem_wdata;
      end
    end
  end

  assign rd_char     = rd_char_q;
  assign cursor_addr = cursor_q;
  assign disp_on     = disp_q;
  assign cursor_on   = curs_q;
  assign blink_on    = blink_q;
  assign busy        = (state_q == ST_CLEAR);
  assign wr_strobe   = wr_strobe_q;
  assign err         = err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb/tb_lcd_bus_receiver.sv - self-checking bench for lcd_bus_receiver

module tb_lcd_bus_receiver;

  localparam logic [7:0] BLANK = 8'h20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic       lcd_e = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_index = 5'd0;
  logic [7:0] rd_char;
  logic [6:0] cursor_addr;
  logic       disp_on, cursor_on, blink_on, busy, wr_strobe, err;

  always #5 clk = ~clk;

  lcd_bus_receiver #(.BLANK_CHAR(8'h20), .LINE_LEN(16)) dut (
    .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data(lcd_data), .rd_index(rd_index), .rd_char(rd_char),
    .cursor_addr(cursor_addr), .disp_on(disp_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .busy(busy), .wr_strobe(wr_strobe), .err(err)
  );

  // Reference model state
  logic [7:0] m_shadow [32];
  int         m_cursor, m_busy;
  bit         m_id, m_cg, m_disp, m_curs, m_blink, m_wr, m_err;
  logic [7:0] m_rd;
  bit         model_on = 1'b0;

  int         pend_seq = 0, done_seq = 0;
  bit         p_rs, p_rw;
  logic [7:0] p_d;
  bit         rand_rd = 1'b0;

  // Address space seen as one 80-position ring: line 1 then line 2
  function automatic int step_addr(int a, bit inc);
    int pos;
    pos = (a < 64) ? a : a - 64 + 40;
    pos = inc ? (pos + 1) % 80 : (pos + 79) % 80;
    return (pos < 40) ? pos : pos - 40 + 64;
  endfunction

  function automatic int char_index(int a);
    if (a < 16) return a;
    if (a >= 64 && a < 80) return a - 64 + 16;
    return -1;
  endfunction

  task automatic model_apply(bit rs, bit rw, logic [7:0] d);
    int a, idx;
    if (rw) begin
      m_err = 1'b1;
    end else if (rs) begin
      if (!m_cg) begin
        idx = char_index(m_cursor);
        if (idx >= 0) m_shadow[idx] = d;
        m_wr = 1'b1;
        m_cursor = step_addr(m_cursor, m_id);
      end
    end else if (d >= 8'h80) begin
      m_cg = 1'b0;
      a = int'(d[6:0]);
      if (a >= 40 && a < 64) begin m_cursor = 64; m_err = 1'b1; end
      else if (a >= 104)     begin m_cursor = 0;  m_err = 1'b1; end
      else m_cursor = a;
    end else if (d >= 8'h40) begin
      m_cg = 1'b1;
    end else if (d >= 8'h10 && d < 8'h20) begin
      if (!d[3]) m_cursor = step_addr(m_cursor, d[2]);
    end else if (d >= 8'h08 && d < 8'h10) begin
      {m_disp, m_curs, m_blink} = d[2:0];
    end else if (d >= 8'h04 && d < 8'h08) begin
      m_id = d[1];
    end else if (d >= 8'h02 && d < 8'h04) begin
      m_cursor = 0;
    end else if (d == 8'h01) begin
      m_busy = 32;
      m_cursor = 0;
      m_id = 1'b1;
    end
  endtask

  always @(posedge clk) begin : model
    bit was_busy;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_shadow[i] = BLANK;
      m_cursor = 0; m_id = 1'b1; m_cg = 1'b0;
      m_disp = 1'b0; m_curs = 1'b0; m_blink = 1'b0;
      m_busy = 0; m_wr = 1'b0; m_err = 1'b0; m_rd = BLANK;
      done_seq = pend_seq;
      model_on = 1'b1;
    end else begin
      was_busy = (m_busy > 0);
      m_rd = m_shadow[rd_index];
      m_wr = 1'b0;
      m_err = 1'b0;
      if (was_busy) begin
        m_shadow[32 - m_busy] = BLANK;
        m_busy--;
      end
      if (pend_seq != done_seq) begin
        done_seq = pend_seq;
        if (was_busy) m_err = 1'b1;
        else model_apply(p_rs, p_rw, p_d);
      end
    end
  end

  // Compare process: model checks every cycle plus posted literal pins
  int    errors = 0, checks = 0;
  int    strobe_cnt = 0, err_cnt = 0, busy_run = 0, last_run = 0;
  bit    busy_prev = 1'b0;
  int    pin_seq = 0, pin_done = 0, pin_sel = 0, pin_exp = 0;
  string pin_name = "";

  task automatic chk(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    int act;
    if (model_on) begin
      chk("cursor_addr", int'(cursor_addr), m_cursor);
      chk("dcb", int'({disp_on, cursor_on, blink_on}), int'({m_disp, m_curs, m_blink}));
      chk("busy", int'(busy), int'(m_busy > 0));
      chk("wr_strobe", int'(wr_strobe), int'(m_wr));
      chk("err", int'(err), int'(m_err));
      chk("rd_char", int'(rd_char), int'(m_rd));
    end
    if (wr_strobe) strobe_cnt++;
    if (err) err_cnt++;
    if (busy) busy_run++;
    else if (busy_prev) begin last_run = busy_run; busy_run = 0; end
    busy_prev = busy;
    if (pin_seq != pin_done) begin
      pin_done = pin_seq;
      if (pin_sel == 8) begin
        strobe_cnt = 0; err_cnt = 0; last_run = 0;
      end else begin
        case (pin_sel)
          0: act = int'(cursor_addr);
          1: act = int'(rd_char);
          2: act = int'(busy);
          3: act = int'({disp_on, cursor_on, blink_on});
          4: act = strobe_cnt;
          5: act = err_cnt;
          default: act = last_run;
        endcase
        chk(pin_name, act, pin_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rd) rd_index = 5'($urandom_range(0, 31));
  endtask

  task automatic pin(int sel, int expected, string name);
    pin_sel = sel; pin_exp = expected; pin_name = name;
    pin_seq++;
    tick();
  endtask

  task automatic clr_counts();
    pin(8, 0, "clear");
  endtask

  task automatic xfer(bit rs, bit rw, logic [7:0] d, int hold = 1, int gap = 1);
    tick();
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (hold) tick();
    lcd_e = 1'b0;
    p_rs = rs; p_rw = rw; p_d = d;
    pend_seq++;
    repeat (gap) tick();
  endtask

  task automatic read_char(int idx, int expected, string name);
    rd_index = 5'(idx);
    tick();
    pin(1, expected, name);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    pin(0, 0, "reset_cursor");
    pin(1, 8'h20, "reset_rd_char");
    pin(2, 0, "reset_busy");
    pin(3, 0, "reset_dcb");

    // Basic writes on line 1
    clr_counts();
    xfer(0, 0, 8'h80);
    xfer(1, 0, 8'h41);
    xfer(1, 0, 8'h42);
    pin(0, 2, "t1_cursor");
    pin(4, 2, "t1_strobes");
    read_char(1, 8'h42, "t1_entry1");
    read_char(0, 8'h41, "t1_entry0");

    // Line 2 fill, non-visible address, wrap to line 2
    xfer(0, 0, 8'hC0);
    for (int i = 0; i < 16; i++) xfer(1, 0, 8'(8'h30 + i));
    pin(0, 8'h50, "t2_cursor_after_fill");
    read_char(31, 8'h3F, "t2_entry31");
    xfer(0, 0, 8'hA7);
    xfer(1, 0, 8'h58);
    pin(0, 8'h40, "t2_cursor_wrap");
    xfer(1, 0, 8'h59);
    read_char(16, 8'h59, "t2_entry16");

    // Decrement wraps from 0x00 to 0x67
    xfer(0, 0, 8'h04);
    xfer(0, 0, 8'h80);
    xfer(1, 0, 8'h55);
    pin(0, 8'h67, "t3_cursor_dec_wrap");
    read_char(0, 8'h55, "t3_entry0");
    xfer(0, 0, 8'h06);

    // Clear with an edge arriving mid-fill
    clr_counts();
    xfer(0, 0, 8'h01);
    xfer(1, 0, 8'h77);
    for (int i = 0; i < 80 && busy; i++) tick();
    pin(2, 0, "t4_busy_done");
    pin(6, 32, "t4_busy_cycles");
    pin(5, 1, "t4_err_count");
    pin(0, 0, "t4_cursor");
    read_char(0, 8'h20, "t4_entry0");
    read_char(16, 8'h20, "t4_entry16");
    read_char(31, 8'h20, "t4_entry31");

    // Display control, CGRAM mode, bad DDRAM address
    xfer(0, 0, 8'h0F);
    pin(3, 7, "t5_dcb_on");
    xfer(0, 0, 8'h0C);
    pin(3, 4, "t5_dcb_disp_only");
    clr_counts();
    xfer(0, 0, 8'h40);
    xfer(1, 0, 8'h11);
    pin(4, 0, "t5_cg_no_strobe");
    xfer(0, 0, 8'hB0);
    pin(0, 8'h40, "t5_bad_addr_cursor");
    pin(5, 1, "t5_bad_addr_err");

    // Reset in the middle of a clear, then a read transaction
    xfer(1, 0, 8'h66);
    xfer(0, 0, 8'h01);
    repeat (5) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    pin(2, 0, "t6_busy_after_reset");
    pin(3, 0, "t6_dcb_after_reset");
    pin(0, 0, "t6_cursor_after_reset");
    read_char(16, 8'h20, "t6_entry16");
    clr_counts();
    xfer(0, 1, 8'h00);
    pin(5, 1, "t6_read_err");
    pin(4, 0, "t6_read_no_strobe");
    pin(0, 0, "t6_read_cursor");

    // Randomized traffic checked cycle by cycle against the model
    rand_rd = 1'b1;
    for (int n = 0; n < 400; n++) begin
      bit         rs, rw;
      logic [7:0] d;
      rs = 1'($urandom_range(0, 1));
      rw = ($urandom_range(0, 9) == 0);
      d  = 8'($urandom_range(0, 255));
      if (!rs && $urandom_range(0, 24) == 0) d = 8'h01;
      xfer(rs, rw, d, $urandom_range(1, 2), $urandom_range(1, 3));
    end
    rand_rd = 1'b0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Receiving end of the HD44780-style parallel LCD bus that the LCD driver transmits on (lcd_rs, lcd_rw, lcd_e, lcd_data).
- Decodes the instruction and data writes, tracks the cursor address, entry mode and display-control state, and keeps a 32-character shadow of the visible 2x16 DDRAM.
- The shadow is read back by character index, using the same 0..31 numbering as index_char.
- Used as an on-chip display mirror and as a checker for the driver in simulation.

Parameters:
- BLANK_CHAR, 8'h20: fill value for reset, clear, and reads outside the visible range.
- LINE_LEN, 16: visible characters per line; fixed at 16 for this revision.

Ports:
- clk  in  1  system clock; the same clock as the LCD driver.
- rst  in  1  synchronous, active-high reset.
- lcd_rs  in  1  register select: 0 = instruction, 1 = data.
- lcd_rw  in  1  read/write: 0 = write, 1 = read.
- lcd_e  in  1  enable strobe; the bus is latched on its falling edge.
- lcd_data  in  8  bus data.
- rd_index  in  5  shadow read index: 0-15 is line 1, 16-31 is line 2.
- rd_char  out  8  character at rd_index; registered.
- cursor_addr  out  7  current DDRAM address counter.
- disp_on  out  1  display-control D bit.
- cursor_on  out  1  display-control C bit.
- blink_on  out  1  display-control B bit.
- busy  out  1  high while a clear-fill is in progress.
- wr_strobe  out  1  one-cycle pulse per accepted data write.
- err  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset:
  - All 32 shadow entries = BLANK_CHAR; rd_char = BLANK_CHAR.
  - cursor_addr = 0; increment direction (id) = 1; cg_mode = 0.
  - disp_on, cursor_on, blink_on = 0; busy = 0; wr_strobe = 0; err = 0.
  - State = IDLE.
  - Reset asserted during a clear aborts the fill; the reset values above win.
- Sampling:
  - Register lcd_e, lcd_rs, lcd_rw and lcd_data every cycle (e_q, rs_q, rw_q, d_q).
  - Falling edge = e_q & ~lcd_e. On that cycle the transaction is {rs_q, rw_q, d_q}.
  - The transaction is decoded and applied in the same cycle. Its effect is visible on the outputs on the next clock.
- Reads: rw_q = 1 is not supported. The transaction is ignored and err pulses.
- Instruction decode (rs_q = 0), by the highest set bit of d_q:
  - 0x01 clear: go to CLEAR; cursor_addr = 0; id = 1.
  - 0x02-0x03 return home: cursor_addr = 0.
  - 0x04-0x07 entry mode: id = d_q[1]; the shift bit is ignored.
  - 0x08-0x0F display control: disp_on = d_q[2], cursor_on = d_q[1], blink_on = d_q[0].
  - 0x10-0x1F shift: if d_q[3] = 0, step cursor_addr right when d_q[2] = 1, left otherwise. Display shift (d_q[3] = 1) is ignored.
  - 0x20-0x3F function set: accepted, no state change.
  - 0x40-0x7F set CGRAM address: cg_mode = 1.
  - 0x80-0xFF set DDRAM address: cg_mode = 0; cursor_addr = d_q[6:0].
    - Address 0x28-0x3F is replaced by 0x40 and err pulses.
    - Address 0x68-0x7F is replaced by 0x00 and err pulses.
  - 0x00: no operation.
- Data write (rs_q = 0 is not a data write; rs_q = 1, rw_q = 0):
  - If cg_mode = 1: discard the data, do not move the cursor, no wr_strobe.
  - Otherwise:
    - If cursor_addr is 0x00-0x0F, store to entry cursor_addr.
    - If cursor_addr is 0x40-0x4F, store to entry 16 + cursor_addr[3:0].
    - Other valid addresses are not stored.
    - In all these cases wr_strobe pulses and the cursor steps by id.
- Cursor step (wrap-around):
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00; otherwise +1.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27; otherwise -1.
- CLEAR state:
  - busy = 1. One entry per cycle is written with BLANK_CHAR, entries 0..31, then the block returns to IDLE.
  - busy is high for exactly 32 cycles, beginning the cycle after the clear edge.
  - A falling edge during CLEAR is dropped and err pulses.
- Read port: rd_char <= shadow[rd_index] each cycle, so latency is 1 clock.
- Simultaneous events: a clear-fill write and a data write never coincide, because edges are dropped while busy.

Test Plan:
- Reset, then write instr 0x80 followed by data 0x41, 0x42 → entries 0, 1 = 0x41, 0x42; cursor_addr = 0x02; two wr_strobe pulses; rd_index = 1 gives rd_char = 0x42 one cycle later.
- Instr 0xC0, then 16 data writes 0x30..0x3F → entries 16..31 = 0x30..0x3F; cursor_addr = 0x50. Then instr 0xA7 (DDRAM 0x27) and data 0x58 → not stored; cursor_addr = 0x40. Then data 0x59 → entry 16 = 0x59.
- Instr 0x04 (decrement), instr 0x80, data 0x55 → entry 0 = 0x55; cursor_addr = 0x67.
- Fill entries, send instr 0x01 → busy high exactly 32 cycles; all rd_char reads return 0x20; cursor_addr = 0. A data edge during busy → err pulses and no entry changes.
- Instr 0x0F then 0x0C → disp/cursor/blink = 1/1/1, then 1/0/0. Instr 0x40 then data 0x11 → no store, no strobe. Instr 0xB0 → cursor_addr = 0x40, err pulses.
- Mid-CLEAR reset, and a read transaction (rw = 1, E pulse) → reset values restored; the read gives an err pulse only.
